// File: rtl/jt51_wrq.sv
// jt51_wrq: CPU write FIFO and register-file update sequencer.
// Optional JT51_WRQ_OVF_EN adds a sticky overflow flag (ovf/ovf_clr).
module jt51_wrq #(
    parameter int DEPTH = 4,
    parameter int TMO   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_din,
    output logic       cpu_full,
    output logic       wrq_busy,
    output logic [7:0] d_in,
    output logic [1:0] op,
    output logic [2:0] ch,
    output logic       up_kon,
    output logic       up_rl,
    output logic       up_kc,
    output logic       up_kf,
    output logic       up_pms,
    output logic       up_dt1,
    output logic       up_tl,
    output logic       up_ks,
    output logic       up_amsen,
    output logic       up_dt2,
    output logic       up_d1l,
    input  logic       reg_busy,
    output logic       glb_wr,
    output logic [4:0] glb_addr,
    output logic [7:0] glb_data
`ifdef JT51_WRQ_OVF_EN
    ,
    input  logic       ovf_clr,
    output logic       ovf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO, GAP} state_t;

    state_t          state, state_nx;
    logic [15:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push, pop;
    logic [7:0]      head_addr, head_data;
    logic [10:0]     dec_sel, sel_q, strobe;
    logic            dec_glb;
    logic [2:0]      tmo_cnt;

    assign {head_addr, head_data} = mem[rd_ptr];
    assign cpu_full = (count == CW'(DEPTH));
    assign push     = cpu_wr & ~cpu_full;
    assign pop      = (state == IDLE) & (count != '0) & ~reg_busy;
    assign wrq_busy = (count != '0) | (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cpu_addr, cpu_din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // strobe index: 0 kon, 1-4 rl/kc/kf/pms, 5-10 dt1..d1l
    always_comb begin
        dec_sel = '0;
        dec_glb = 1'b0;
        unique case (1'b1)
            head_addr[7:5] == 3'd0: begin
                if (head_addr[4:0] == 5'h08) dec_sel[0] = 1'b1;
                else                         dec_glb    = 1'b1;
            end
            head_addr[7:5] == 3'd1:
                dec_sel = 11'b000_0000_0010 << head_addr[4:3];
            default:
                dec_sel = 11'b000_0010_0000 << (head_addr[7:5] - 3'd2);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pop && !dec_glb) state_nx = WAIT_HI;
            WAIT_HI: begin
                if (reg_busy)                     state_nx = WAIT_LO;
                else if (tmo_cnt == 3'(TMO - 1))  state_nx = GAP;
            end
            WAIT_LO: if (!reg_busy) state_nx = GAP;
            GAP:     state_nx = IDLE;
        endcase
    end

    always_comb begin
        strobe = '0;
        if (state == WAIT_HI || state == WAIT_LO) strobe = sel_q;
    end

    assign {up_d1l, up_dt2, up_amsen, up_ks, up_tl, up_dt1,
            up_pms, up_kf, up_kc, up_rl, up_kon} = strobe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt <= '0;
        else if (state == WAIT_HI && state_nx == WAIT_HI)
            tmo_cnt <= tmo_cnt + 3'd1;
        else
            tmo_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= '0;
            d_in     <= '0;
            op       <= '0;
            ch       <= '0;
            glb_wr   <= 1'b0;
            glb_addr <= '0;
            glb_data <= '0;
        end else begin
            glb_wr <= pop & dec_glb;
            if (pop) {op, ch} <= head_addr[4:0];
            if (pop && dec_glb) begin
                glb_addr <= head_addr[4:0];
                glb_data <= head_data;
            end
            if (pop && !dec_glb) begin
                sel_q <= dec_sel;
                d_in  <= head_data;
            end
        end
    end

`ifdef JT51_WRQ_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  ovf <= 1'b0;
        else if (cpu_wr && cpu_full) ovf <= 1'b1;
        else if (ovf_clr)            ovf <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_jt51_wrq.sv
// Bench for jt51_wrq: directed scenarios plus random traffic against
// an ordered write model and a simple register-file busy responder.
module tb_jt51_wrq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_wr = 1'b0;
    logic [7:0] cpu_addr = '0;
    logic [7:0] cpu_din = '0;
    logic       reg_busy = 1'b0;
    logic       cpu_full, wrq_busy, glb_wr;
    logic [7:0] d_in, glb_data;
    logic [1:0] op;
    logic [2:0] ch;
    logic [4:0] glb_addr;
    logic       up_kon, up_rl, up_kc, up_kf, up_pms, up_dt1;
    logic       up_tl, up_ks, up_amsen, up_dt2, up_d1l;
`ifdef JT51_WRQ_OVF_EN
    logic       ovf_clr = 1'b0;
    logic       ovf;
`endif
    logic [10:0] sv;

    always #5 clk = ~clk;

    assign sv = {up_d1l, up_dt2, up_amsen, up_ks, up_tl, up_dt1,
                 up_pms, up_kf, up_kc, up_rl, up_kon};

    jt51_wrq #(.DEPTH(4), .TMO(4)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_full(cpu_full), .wrq_busy(wrq_busy),
        .d_in(d_in), .op(op), .ch(ch), .up_kon(up_kon), .up_rl(up_rl),
        .up_kc(up_kc), .up_kf(up_kf), .up_pms(up_pms), .up_dt1(up_dt1),
        .up_tl(up_tl), .up_ks(up_ks), .up_amsen(up_amsen), .up_dt2(up_dt2),
        .up_d1l(up_d1l), .reg_busy(reg_busy), .glb_wr(glb_wr),
        .glb_addr(glb_addr), .glb_data(glb_data)
`ifdef JT51_WRQ_OVF_EN
        , .ovf_clr(ovf_clr), .ovf(ovf)
`endif
    );

    int checks = 0;
    int errors = 0;

    // events: {kind[3:0], addr[4:0] (op,ch or glb_addr), data[7:0]}
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    logic [16:0] bad_obs, bad_exp;
    logic [10:0] prev_sv;
    logic [7:0]  prev_d;
    logic [4:0]  prev_oc;
    int multi_err, gap_err, hold_err, glb_run, glb_run_max;

    bit resp_en, resp_rand, armed;
    int resp_delay, resp_len, delay_left, busy_left;

    function automatic logic [16:0] model_event(logic [7:0] a, logic [7:0] d);
        int k;
        if (a == 8'h08)     k = 0;
        else if (a < 8'h20) k = 11;
        else if (a < 8'h28) k = 1;
        else if (a < 8'h30) k = 2;
        else if (a < 8'h38) k = 3;
        else if (a < 8'h40) k = 4;
        else                k = 5 + (int'(a) - 'h40) / 32;
        return {4'(k), a[4:0], d};
    endfunction

    function automatic int q_mismatch();
        int n = 0;
        bad_obs = '0;
        bad_exp = '0;
        if (obs_q.size() != exp_q.size()) n++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) begin
                if (n == 0) begin
                    bad_obs = obs_q[i];
                    bad_exp = exp_q[i];
                end
                n++;
            end
        return n;
    endfunction

    task automatic clear_mon();
        exp_q.delete();
        obs_q.delete();
        prev_sv = '0;
        multi_err = 0;
        gap_err = 0;
        hold_err = 0;
        glb_run = 0;
        glb_run_max = 0;
    endtask

    task automatic resp_idle();
        resp_en = 1'b0;
        armed = 1'b1;
        delay_left = -1;
        busy_left = 0;
        reg_busy = 1'b0;
    endtask

    task automatic tick();
        int k;
        @(negedge clk);
        if ($countones(sv) > 1) multi_err++;
        if (sv != 0 && prev_sv != 0 && sv != prev_sv) gap_err++;
        if (sv != 0 && sv == prev_sv && (d_in != prev_d || {op, ch} != prev_oc))
            hold_err++;
        if (sv != 0 && prev_sv == 0) begin
            k = 0;
            for (int i = 0; i < 11; i++) if (sv[i]) k = i;
            obs_q.push_back({4'(k), op, ch, d_in});
        end
        if (glb_wr) begin
            obs_q.push_back({4'd11, glb_addr, glb_data});
            glb_run++;
            if (glb_run > glb_run_max) glb_run_max = glb_run;
        end else glb_run = 0;
        prev_sv = sv;
        prev_d = d_in;
        prev_oc = {op, ch};
        if (resp_en) begin
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) reg_busy = 1'b0;
            end else if (delay_left >= 0) begin
                if (delay_left == 0) begin
                    reg_busy = 1'b1;
                    busy_left = resp_len;
                end
                delay_left--;
            end else if (sv != 0 && armed) begin
                armed = 1'b0;
                if (resp_rand) begin
                    resp_delay = $urandom_range(0, 6);
                    resp_len = $urandom_range(1, 8);
                end
                if (resp_delay == 0) begin
                    reg_busy = 1'b1;
                    busy_left = resp_len;
                end else delay_left = resp_delay - 1;
            end
            if (sv == 0 && busy_left == 0 && delay_left < 0) armed = 1'b1;
        end
    endtask

    task automatic write(input logic [7:0] a, input logic [7:0] d, input bit keep);
        cpu_wr = 1'b1;
        cpu_addr = a;
        cpu_din = d;
        if (keep) exp_q.push_back(model_event(a, d));
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < budget) begin
            tick();
            n++;
            if (!wrq_busy && !reg_busy && delay_left < 0 && busy_left == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({sv, glb_wr, cpu_full, wrq_busy} !== 14'd0) begin
            errors++;
            $display("FAIL reset_ctl: got %h required 0", {sv, glb_wr, cpu_full, wrq_busy});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({d_in, op, ch} !== 13'd0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", {d_in, op, ch});
        end
        checks++;
        if ({glb_addr, glb_data} !== 13'd0) begin
            errors++;
            $display("FAIL reset_glb: got %h required 0", {glb_addr, glb_data});
        end
        checks++;
        if ({sv, wrq_busy, cpu_full} !== 13'd0) begin
            errors++;
            $display("FAIL reset_release: got %h required 0", {sv, wrq_busy, cpu_full});
        end
`ifdef JT51_WRQ_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b required 0", ovf);
        end
`endif
    endtask

    task automatic test_single_kc();
        int hi;
        bit ok;
        clear_mon();
        resp_idle();
        resp_en = 1'b1;
        resp_rand = 1'b0;
        resp_delay = 0;
        resp_len = 32;
        write(8'h28, 8'h4A, 1'b1);
        checks++;
        if (sv !== 11'd0) begin
            errors++;
            $display("FAIL kc_early: got %h required 0", sv);
        end
        tick();
        checks++;
        if ({sv, ch, d_in} !== {11'b100, 3'd0, 8'h4A}) begin
            errors++;
            $display("FAIL kc_latency: got %h required %h", {sv, ch, d_in},
                     {11'b100, 3'd0, 8'h4A});
        end
        hi = 1;
        for (int i = 0; i < 100 && sv == 11'b100; i++) begin
            tick();
            if (sv == 11'b100) hi++;
        end
        checks++;
        if (hi !== 33) begin
            errors++;
            $display("FAIL kc_hold: got %0d cycles required 33", hi);
        end
        checks++;
        if ({sv, wrq_busy} !== 12'd1) begin
            errors++;
            $display("FAIL kc_gap: got %h required 001", {sv, wrq_busy});
        end
        tick();
        checks++;
        if (wrq_busy !== 1'b0) begin
            errors++;
            $display("FAIL kc_idle: got %b required 0", wrq_busy);
        end
        drain(200, ok);
        checks++;
        if (q_mismatch() !== 0 || !ok || multi_err + gap_err + hold_err != 0) begin
            errors++;
            $display("FAIL kc_events: got %h required %h (n=%0d ok=%0d e=%0d/%0d/%0d)",
                     bad_obs, bad_exp, obs_q.size(), ok, multi_err, gap_err, hold_err);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_mon();
        resp_idle();
        resp_en = 1'b1;
        resp_rand = 1'b0;
        resp_delay = 1;
        resp_len = 3;
        write(8'h63, 8'h7F, 1'b1);
        write(8'hE5, 8'h0F, 1'b1);
        drain(300, ok);
        checks++;
        if (q_mismatch() !== 0 || !ok) begin
            errors++;
            $display("FAIL b2b_order: got %h required %h (n=%0d ok=%0d)",
                     bad_obs, bad_exp, obs_q.size(), ok);
        end
        checks++;
        if (multi_err + gap_err + hold_err !== 0) begin
            errors++;
            $display("FAIL b2b_gap: got %0d/%0d/%0d violations required 0",
                     multi_err, gap_err, hold_err);
        end
    endtask

    task automatic test_globals();
        bit ok;
        clear_mon();
        resp_idle();
        resp_en = 1'b1;
        write(8'h14, 8'h35, 1'b1);
        write(8'h10, 8'h01, 1'b1);
        write(8'h11, 8'h02, 1'b1);
        drain(100, ok);
        checks++;
        if (q_mismatch() !== 0 || !ok) begin
            errors++;
            $display("FAIL glb_events: got %h required %h (n=%0d ok=%0d)",
                     bad_obs, bad_exp, obs_q.size(), ok);
        end
        checks++;
        if (glb_run_max !== 3) begin
            errors++;
            $display("FAIL glb_run: got %0d required 3", glb_run_max);
        end
    endtask

    task automatic test_timeout();
        int hi;
        clear_mon();
        resp_idle();
        write(8'h08, 8'h78, 1'b1);
        tick();
        checks++;
        if ({sv, d_in} !== {11'b1, 8'h78}) begin
            errors++;
            $display("FAIL kon_start: got %h required %h", {sv, d_in}, {11'b1, 8'h78});
        end
        hi = 1;
        for (int i = 0; i < 50 && sv == 11'b1; i++) begin
            tick();
            if (sv == 11'b1) hi++;
        end
        checks++;
        if (hi !== 4) begin
            errors++;
            $display("FAIL kon_tmo: got %0d cycles required 4", hi);
        end
        checks++;
        if ({sv, wrq_busy} !== 12'd1) begin
            errors++;
            $display("FAIL kon_gap: got %h required 001", {sv, wrq_busy});
        end
        tick();
        checks++;
        if (wrq_busy !== 1'b0) begin
            errors++;
            $display("FAIL kon_idle: got %b required 0", wrq_busy);
        end
    endtask

    task automatic test_full();
        logic [7:0] a[5];
        logic [7:0] d[5];
        bit ok;
        clear_mon();
        resp_idle();
        reg_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a[i] = 8'($urandom_range(0, 255));
            d[i] = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < 3; i++) write(a[i], d[i], 1'b1);
        checks++;
        if ({cpu_full, wrq_busy} !== 2'b01) begin
            errors++;
            $display("FAIL full_3: got %b required 01", {cpu_full, wrq_busy});
        end
        write(a[3], d[3], 1'b1);
        checks++;
        if (cpu_full !== 1'b1) begin
            errors++;
            $display("FAIL full_4: got %b required 1", cpu_full);
        end
        write(a[4], d[4], 1'b0);
        checks++;
        if ({cpu_full, 4'(obs_q.size())} !== 5'b10000) begin
            errors++;
            $display("FAIL full_drop: got full=%b events=%0d required 1/0",
                     cpu_full, obs_q.size());
        end
`ifdef JT51_WRQ_OVF_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b required 1", ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got %b required 0", ovf);
        end
`endif
        reg_busy = 1'b0;
        resp_en = 1'b1;
        resp_rand = 1'b1;
        drain(500, ok);
        checks++;
        if (q_mismatch() !== 0 || !ok || multi_err + gap_err + hold_err != 0) begin
            errors++;
            $display("FAIL full_drain: got %h required %h (n=%0d ok=%0d)",
                     bad_obs, bad_exp, obs_q.size(), ok);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        resp_idle();
        resp_en = 1'b1;
        resp_rand = 1'b0;
        resp_delay = 0;
        resp_len = 20;
        write(8'h65, 8'h11, 1'b0);
        write(8'h21, 8'h33, 1'b0);
        write(8'h09, 8'h44, 1'b0);
        for (int i = 0; i < 20 && !(up_tl && reg_busy); i++) tick();
        tick();
        tick();
        checks++;
        if ({up_tl, reg_busy, wrq_busy} !== 3'b111) begin
            errors++;
            $display("FAIL rst_pre: got %b required 111", {up_tl, reg_busy, wrq_busy});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sv, wrq_busy, cpu_full} !== 13'd0) begin
            errors++;
            $display("FAIL rst_async: got %h required 0", {sv, wrq_busy, cpu_full});
        end
        resp_idle();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({sv, wrq_busy, cpu_full, glb_wr} !== 14'd0) begin
            errors++;
            $display("FAIL rst_after: got %h required 0", {sv, wrq_busy, cpu_full, glb_wr});
        end
        clear_mon();
        resp_en = 1'b1;
        write(8'h3A, 8'h5C, 1'b1);
        drain(200, ok);
        checks++;
        if (q_mismatch() !== 0 || !ok) begin
            errors++;
            $display("FAIL rst_flush: got %h required %h (n=%0d ok=%0d)",
                     bad_obs, bad_exp, obs_q.size(), ok);
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        bit ok;
        clear_mon();
        resp_idle();
        resp_en = 1'b1;
        resp_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && !cpu_full) begin
                a = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) a[7:5] = 3'd0;
                write(a, 8'($urandom_range(0, 255)), 1'b1);
            end else tick();
        end
        drain(20000, ok);
        checks++;
        if (q_mismatch() !== 0 || !ok) begin
            errors++;
            $display("FAIL rand_order: got %h required %h (n=%0d/%0d ok=%0d)",
                     bad_obs, bad_exp, obs_q.size(), exp_q.size(), ok);
        end
        checks++;
        if (multi_err + gap_err + hold_err !== 0) begin
            errors++;
            $display("FAIL rand_strobe: got %0d/%0d/%0d violations required 0",
                     multi_err, gap_err, hold_err);
        end
    endtask

    initial begin
        clear_mon();
        resp_idle();
        resp_rand = 1'b0;
        resp_delay = 0;
        resp_len = 1;
        test_reset();
        test_single_kc();
        test_back_to_back();
        test_globals();
        test_timeout();
        test_full();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
